dict_loader: RTL and testbench
==============================

Name: dict_loader

Overview:
- Boot-time sequencer that sits upstream of the compression controller's dictionary write ports.
- On start, it streams a dictionary image from instruction memory.
- It validates the image header and drives the per-field dictionary write strobes, one entry per cycle-pulse.
- It shares the controller's memory request protocol; the controller must stay idle while busy is high.

Parameters:
- FIELD1_VAL_WIDTH, 7, width of a field-1 dictionary value (opcode field)
- FIELD2_VAL_WIDTH, 12, width of a field-2 dictionary value
- FIELD3_VAL_WIDTH, 13, width of a field-3 dictionary value
- FIELD1_MAX_ENTRIES, 8, capacity of dictionary 1 (2^FIELD1_KEY_WIDTH)
- FIELD2_MAX_ENTRIES, 64, capacity of dictionary 2
- FIELD3_MAX_ENTRIES, 128, capacity of dictionary 3
- DICT_BASE_ADDR, 32'h0001_0000, byte address of the image header word (word aligned)
- MAGIC, 8'hD1, required header tag

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a load
- busy  out  1  high from the cycle after an accepted start until DONE or ERROR is entered
- done  out  1  level; high while in DONE
- error  out  1  level; high while in ERROR
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory has data on mem_req_rdata this cycle
- mem_req_addr  out  32  word-aligned byte address
- mem_req_rdata  in  32  read data
- dict1_write_enable  out  1  one-cycle write strobe, dictionary 1
- dict1_write_val  out  FIELD1_VAL_WIDTH  value for dictionary 1
- dict2_write_enable  out  1  one-cycle write strobe, dictionary 2
- dict2_write_val  out  FIELD2_VAL_WIDTH  value for dictionary 2
- dict3_write_enable  out  1  one-cycle write strobe, dictionary 3
- dict3_write_val  out  FIELD3_VAL_WIDTH  value for dictionary 3

Behaviour:
- Reset (async, resetn low): state IDLE; all outputs 0; mem_req_addr 0; counters 0. Reset mid-load aborts immediately. Dictionaries are not cleared by this block.
- Image layout: word 0 is the header, {MAGIC[31:24], cnt3[23:16], cnt2[15:8], cnt1[7:0]}. Then cnt1 words for dictionary 1, cnt2 for dictionary 2, cnt3 for dictionary 3, contiguous. Each value is right-aligned in its word; upper bits are ignored.
- Word n address = DICT_BASE_ADDR + 4*n, using a 10-bit word index with zero-extension.
- Memory handshake, one outstanding read:
  - mem_req_valid and mem_req_addr are registered and held stable until mem_req_ready is sampled high.
  - In the cycle mem_req_ready is high, rdata is captured and mem_req_valid falls the next cycle.
  - The next request is raised no earlier than the following cycle, so at least one idle cycle separates requests.
  - mem_req_ready while valid is low is ignored.
- States:
  - IDLE: waits for start; then goes to HEADER, with index 0 and busy 1.
  - HEADER: reads word 0.
    - Magic mismatch, cnt1>FIELD1_MAX_ENTRIES, cnt2>FIELD2_MAX_ENTRIES or cnt3>FIELD3_MAX_ENTRIES -> ERROR.
    - Otherwise latch the counts and go to the first LOADk with a nonzero count; if all counts are 0, go to DONE.
  - LOAD1/LOAD2/LOAD3: for each captured word, assert dictk_write_enable for exactly one cycle, the cycle after capture, with dictk_write_val = rdata[WIDTHk-1:0].
    - At most one write_enable is high in any cycle.
    - After the last entry of a dictionary, skip zero-count dictionaries, in order.
    - After the final write of the last nonzero dictionary, go to DONE.
  - DONE / ERROR: busy 0, mem_req_valid 0. start re-enters HEADER and clears done/error in the same transition.
- start while busy is ignored.
- Latency: with a memory that answers one cycle after valid, each word costs 3 cycles (valid, ready, gap). Total load time is 3*(1+cnt1+cnt2+cnt3) cycles plus 1 cycle from start to the first valid.
- Count equal to max is legal. Counts are 8-bit, so the loader never writes more than 255 entries per field.

Test Plan:
- Header 32'hD1_01_03_02, entries 0x13,0x33 / 0x001,0x7FF,0xABC / 0x1FFF, memory ready 1 cycle after valid -> exactly 6 write strobes in order d1,d1,d2,d2,d2,d3.
  - The strobes carry those values masked to width.
  - Addresses run 0x10000..0x10018 step 4.
  - done rises after the last strobe; busy falls in the same cycle.
- Header 32'hD1_00_00_00 -> no write strobes; done after a single memory read.
- Header 32'hA5_01_01_01 -> error=1 and no write strobes; a later start with a corrected image completes with done=1, error=0.
- Header 32'hD1_00_41_00 (cnt2=65 > 64) -> error=1 and no reads beyond the header.
- Memory ready delayed 0, 1 and 7 cycles randomly -> mem_req_valid/addr stay stable until ready; results match the first scenario; start pulses during busy are ignored.
- resetn dropped during the second dict2 read -> all outputs 0 asynchronously; after release the block stays IDLE until start.

Source files
------------

// File: rtl/dict_loader.sv
// Boot-time dictionary loader: reads a header plus entries from memory, then emits one write strobe per entry.
// Each word takes 3 cycles plus the memory wait. Only one read is outstanding; requests hold until mem_req_ready.
module dict_loader #(
  parameter int          FIELD1_VAL_WIDTH   = 7,
  parameter int          FIELD2_VAL_WIDTH   = 12,
  parameter int          FIELD3_VAL_WIDTH   = 13,
  parameter int          FIELD1_MAX_ENTRIES = 8,
  parameter int          FIELD2_MAX_ENTRIES = 64,
  parameter int          FIELD3_MAX_ENTRIES = 128,
  parameter logic [31:0] DICT_BASE_ADDR     = 32'h0001_0000,
  parameter logic [7:0]  MAGIC              = 8'hD1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [31:0]                 mem_req_addr,
  input  logic [31:0]                 mem_req_rdata,
  output logic                        dict1_write_enable,
  output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  output logic                        dict2_write_enable,
  output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  output logic                        dict3_write_enable,
  output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val
);

  localparam logic [8:0] MAX1 = 9'(FIELD1_MAX_ENTRIES);
  localparam logic [8:0] MAX2 = 9'(FIELD2_MAX_ENTRIES);
  localparam logic [8:0] MAX3 = 9'(FIELD3_MAX_ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_LOAD1, S_LOAD2, S_LOAD3, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic        gap_q, gap_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] hdr_q, hdr_d;
  logic [9:0]  idx_q, idx_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  cnt2_q, cnt2_d;
  logic [7:0]  cnt3_q, cnt3_d;
  logic        wr1_q, wr1_d, wr2_q, wr2_d, wr3_q, wr3_d;
  logic [FIELD1_VAL_WIDTH-1:0] val1_q, val1_d;
  logic [FIELD2_VAL_WIDTH-1:0] val2_q, val2_d;
  logic [FIELD3_VAL_WIDTH-1:0] val3_q, val3_d;
  logic        launch;

  logic [7:0] h_cnt1, h_cnt2, h_cnt3;
  logic       hdr_bad;

  assign h_cnt1  = hdr_q[7:0];
  assign h_cnt2  = hdr_q[15:8];
  assign h_cnt3  = hdr_q[23:16];
  assign hdr_bad = (hdr_q[31:24] != MAGIC) || ({1'b0, h_cnt1} > MAX1) ||
                   ({1'b0, h_cnt2} > MAX2) || ({1'b0, h_cnt3} > MAX3);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    hdr_d   = hdr_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    cnt2_d  = cnt2_q;
    cnt3_d  = cnt3_q;
    wr1_d   = 1'b0;
    wr2_d   = 1'b0;
    wr3_d   = 1'b0;
    val1_d  = val1_q;
    val2_d  = val2_q;
    val3_d  = val3_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_HEADER;
          idx_d   = '0;
          gap_d   = 1'b0;
          valid_d = 1'b1;
          addr_d  = DICT_BASE_ADDR;
        end
      end
      default: begin
        if (gap_q) begin
          // Idle cycle after a capture: decide where to go and raise the next request.
          gap_d = 1'b0;
          case (state_q)
            S_HEADER: begin
              if (hdr_bad) begin
                state_d = S_ERROR;
              end else begin
                cnt2_d = h_cnt2;
                cnt3_d = h_cnt3;
                launch = 1'b1;
                if (h_cnt1 != 8'd0) begin
                  state_d = S_LOAD1;
                  rem_d   = h_cnt1;
                end else if (h_cnt2 != 8'd0) begin
                  state_d = S_LOAD2;
                  rem_d   = h_cnt2;
                end else if (h_cnt3 != 8'd0) begin
                  state_d = S_LOAD3;
                  rem_d   = h_cnt3;
                end else begin
                  state_d = S_DONE;
                  launch  = 1'b0;
                end
              end
            end
            default: begin
              if (rem_q != 8'd1) begin
                rem_d  = rem_q - 8'd1;
                launch = 1'b1;
              end else if (state_q == S_LOAD1 && cnt2_q != 8'd0) begin
                state_d = S_LOAD2;
                rem_d   = cnt2_q;
                launch  = 1'b1;
              end else if (state_q != S_LOAD3 && cnt3_q != 8'd0) begin
                state_d = S_LOAD3;
                rem_d   = cnt3_q;
                launch  = 1'b1;
              end else begin
                state_d = S_DONE;
              end
            end
          endcase
          if (launch) begin
            idx_d   = idx_q + 10'd1;
            valid_d = 1'b1;
            addr_d  = DICT_BASE_ADDR + {20'd0, idx_d, 2'b00};
          end
        end else if (valid_q && mem_req_ready) begin
          valid_d = 1'b0;
          gap_d   = 1'b1;
          case (state_q)
            S_HEADER: hdr_d = mem_req_rdata;
            S_LOAD1: begin
              wr1_d  = 1'b1;
              val1_d = mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
            end
            S_LOAD2: begin
              wr2_d  = 1'b1;
              val2_d = mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
            end
            S_LOAD3: begin
              wr3_d  = 1'b1;
              val3_d = mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      gap_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      hdr_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      cnt2_q  <= '0;
      cnt3_q  <= '0;
      wr1_q   <= 1'b0;
      wr2_q   <= 1'b0;
      wr3_q   <= 1'b0;
      val1_q  <= '0;
      val2_q  <= '0;
      val3_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      hdr_q   <= hdr_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      cnt2_q  <= cnt2_d;
      cnt3_q  <= cnt3_d;
      wr1_q   <= wr1_d;
      wr2_q   <= wr2_d;
      wr3_q   <= wr3_d;
      val1_q  <= val1_d;
      val2_q  <= val2_d;
      val3_q  <= val3_d;
    end
  end

  assign busy               = (state_q == S_HEADER) || (state_q == S_LOAD1) ||
                              (state_q == S_LOAD2)  || (state_q == S_LOAD3);
  assign done               = (state_q == S_DONE);
  assign error              = (state_q == S_ERROR);
  assign mem_req_valid      = valid_q;
  assign mem_req_addr       = addr_q;
  assign dict1_write_enable = wr1_q;
  assign dict1_write_val    = val1_q;
  assign dict2_write_enable = wr2_q;
  assign dict2_write_val    = val2_q;
  assign dict3_write_enable = wr3_q;
  assign dict3_write_val    = val3_q;

endmodule

// File: tb/tb_dict_loader.sv
// Bench for dict_loader: memory responder with variable latency, image-level reference model, per-cycle compare.
module tb_dict_loader;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_rdata = '0;
  logic        d1_en, d2_en, d3_en;
  logic [6:0]  d1_val;
  logic [11:0] d2_val;
  logic [12:0] d3_val;

  dict_loader dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .error(error),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rdata(mem_req_rdata),
    .dict1_write_enable(d1_en), .dict1_write_val(d1_val),
    .dict2_write_enable(d2_en), .dict2_write_val(d2_val),
    .dict3_write_enable(d3_en), .dict3_write_val(d3_val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
  endtask

  typedef struct {int f; int v;} wr_t;
  logic [31:0] mem [0:1023];
  wr_t         exp_wr[$];
  wr_t         obs_wr[$];
  logic [31:0] exp_addr[$];
  logic [31:0] obs_addr[$];
  bit          exp_err;
  int          exp_n;
  bit          mon_en = 1'b0;
  int          lat_mode = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    logic [31:0] w;
    w = (a - BASE) >> 2;
    if (a < BASE || w > 32'd1023) return 32'hDEAD_BEEF;
    return mem[w[9:0]];
  endfunction

  // Memory responder: ready after a per-request latency, random noise on ready while idle.
  initial begin
    int wcnt;
    int lat;
    wcnt = 0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (mem_req_valid && resetn) begin
        if (wcnt == 0) begin
          if (lat_mode == 0) lat = 1;
          else case ($urandom_range(0, 2))
            0: lat = 0;
            1: lat = 1;
            default: lat = 7;
          endcase
        end
        mem_req_ready = (wcnt >= lat);
        mem_req_rdata = rd(mem_req_addr);
        if (mem_req_ready) wcnt = 0;
        else wcnt++;
      end else begin
        mem_req_ready = 1'($urandom_range(0, 1));
        mem_req_rdata = $urandom;
        wcnt = 0;
      end
    end
  end

  // Compare process: strobes and request addresses against the model, plus handshake rules.
  initial begin
    bit          pv, pr;
    logic [31:0] pa;
    wr_t         e, o;
    int          nen;
    pv = 0; pr = 0; pa = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        pv = 0; pr = 0;
        continue;
      end
      nen = int'(d1_en) + int'(d2_en) + int'(d3_en);
      if (nen != 0) begin
        chk("one_strobe", nen == 1, nen, 1);
        o.f = d1_en ? 1 : (d2_en ? 2 : 3);
        o.v = d1_en ? int'(d1_val) : (d2_en ? int'(d2_val) : int'(d3_val));
        obs_wr.push_back(o);
        if (exp_wr.size() == 0) chk("extra_write", 1'b0, o.f, 0);
        else begin
          e = exp_wr.pop_front();
          chk("write_field", o.f == e.f, o.f, e.f);
          chk("write_val", o.v == e.v, o.v, e.v);
        end
      end
      if (pv && !pr) chk("req_hold", mem_req_valid && mem_req_addr == pa, mem_req_addr, pa);
      else if (pv && pr) chk("req_drop", !mem_req_valid, mem_req_valid, 0);
      else if (mem_req_valid) begin
        obs_addr.push_back(mem_req_addr);
        if (exp_addr.size() == 0) chk("extra_read", 1'b0, mem_req_addr, 0);
        else begin
          pa = exp_addr.pop_front();
          chk("read_addr", mem_req_addr == pa, mem_req_addr, pa);
        end
      end
      pv = mem_req_valid; pr = mem_req_ready; pa = mem_req_addr;
    end
  end

  // Reference model: derive every read and write from the image in mem.
  task automatic build_expect();
    logic [31:0] h;
    int c1, c2, c3, n;
    h = mem[0];
    c1 = int'(h[7:0]); c2 = int'(h[15:8]); c3 = int'(h[23:16]);
    exp_wr.delete(); exp_addr.delete(); obs_wr.delete(); obs_addr.delete();
    exp_addr.push_back(BASE);
    exp_err = (h[31:24] != 8'hD1) || c1 > 8 || c2 > 64 || c3 > 128;
    exp_n = exp_err ? 0 : c1 + c2 + c3;
    if (!exp_err) begin
      n = 1;
      for (int i = 0; i < c1; i++) begin
        exp_wr.push_back('{f: 1, v: int'(mem[n] % 128)});
        exp_addr.push_back(BASE + 32'(4 * n)); n++;
      end
      for (int i = 0; i < c2; i++) begin
        exp_wr.push_back('{f: 2, v: int'(mem[n] % 4096)});
        exp_addr.push_back(BASE + 32'(4 * n)); n++;
      end
      for (int i = 0; i < c3; i++) begin
        exp_wr.push_back('{f: 3, v: int'(mem[n] % 8192)});
        exp_addr.push_back(BASE + 32'(4 * n)); n++;
      end
    end
  endtask

  task automatic run_load(input string tag, input bit poke);
    int s, took;
    build_expect();
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    took = -1;
    for (int k = 0; k < 8000; k++) begin
      if (done || error) begin
        took = cyc - s;
        break;
      end
      if (poke && busy && $urandom_range(0, 3) == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    chk({tag, " finished"}, took >= 0, took, 0);
    chk({tag, " done"}, done == !exp_err, done, !exp_err);
    chk({tag, " error"}, error == exp_err, error, exp_err);
    chk({tag, " busy_low"}, !busy && !mem_req_valid, {busy, mem_req_valid}, 0);
    chk({tag, " writes_left"}, exp_wr.size() == 0, exp_wr.size(), 0);
    chk({tag, " reads_left"}, exp_addr.size() == 0, exp_addr.size(), 0);
    if (lat_mode == 0)
      chk({tag, " latency"}, took == 3 * (1 + exp_n) + 1, took, 3 * (1 + exp_n) + 1);
  endtask

  task automatic load_s1();
    mem[0] = 32'hD101_0302;
    mem[1] = 32'hFFFF_FF93;
    mem[2] = 32'h0000_0033;
    mem[3] = 32'hABCD_E001;
    mem[4] = 32'h0000_07FF;
    mem[5] = 32'h1234_5ABC;
    mem[6] = 32'hFFFF_FFFF;
  endtask

  task automatic check_s1_literal(input string tag);
    int lf [6];
    int lv [6];
    lf = '{1, 1, 2, 2, 2, 3};
    lv = '{'h13, 'h33, 'h001, 'h7FF, 'hABC, 'h1FFF};
    chk({tag, " n_writes"}, obs_wr.size() == 6, obs_wr.size(), 6);
    for (int i = 0; i < 6 && i < obs_wr.size(); i++) begin
      chk({tag, " lit_field"}, obs_wr[i].f == lf[i], obs_wr[i].f, lf[i]);
      chk({tag, " lit_val"}, obs_wr[i].v == lv[i], obs_wr[i].v, lv[i]);
    end
    chk({tag, " n_reads"}, obs_addr.size() == 7, obs_addr.size(), 7);
    for (int i = 0; i < 7 && i < obs_addr.size(); i++)
      chk({tag, " lit_addr"}, obs_addr[i] == 32'h0001_0000 + 32'(4 * i), obs_addr[i],
          32'h0001_0000 + 32'(4 * i));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c3, k;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, error, mem_req_valid, d1_en, d2_en, d3_en} == 0,
        {busy, done, error, mem_req_valid, d1_en, d2_en, d3_en}, 0);
    chk("reset_addr_vals", {mem_req_addr, d1_val, d2_val, d3_val} == 0,
        {mem_req_addr, d1_val, d2_val, d3_val}, 0);
    resetn = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_no_start", !busy && !mem_req_valid && !done, {busy, mem_req_valid, done}, 0);

    lat_mode = 0;
    load_s1();
    run_load("s1", 1'b0);
    check_s1_literal("s1");

    mem[0] = 32'hD100_0000;
    run_load("zero", 1'b0);
    chk("zero n_reads", obs_addr.size() == 1, obs_addr.size(), 1);
    chk("zero n_writes", obs_wr.size() == 0, obs_wr.size(), 0);

    mem[0] = 32'hA501_0101;
    run_load("bad_magic", 1'b0);
    chk("bad_magic error", error == 1'b1, error, 1);
    chk("bad_magic n_writes", obs_wr.size() == 0, obs_wr.size(), 0);
    mem[0] = 32'hD101_0101;
    run_load("fixed_magic", 1'b0);
    chk("fixed_magic flags", done && !error, {done, error}, 2'b10);

    mem[0] = 32'hD100_4100;
    run_load("cnt2_over", 1'b0);
    chk("cnt2_over n_reads", obs_addr.size() == 1, obs_addr.size(), 1);
    mem[0] = 32'hD100_0009;
    run_load("cnt1_over", 1'b0);
    mem[0] = 32'hD181_0000;
    run_load("cnt3_over", 1'b0);
    for (int i = 1; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'hD180_4008;
    run_load("all_max", 1'b0);

    lat_mode = 1;
    load_s1();
    run_load("s1_slow", 1'b1);
    check_s1_literal("s1_slow");

    for (int r = 0; r < 6; r++) begin
      c1 = $urandom_range(0, 9); c2 = $urandom_range(0, 6); c3 = $urandom_range(0, 6);
      for (int i = 1; i < 32; i++) mem[i] = $urandom;
      mem[0] = {(r == 5) ? 8'h3C : 8'hD1, 8'(c3), 8'(c2), 8'(c1)};
      lat_mode = r % 2;
      run_load("rand", 1'(r % 2));
    end

    // Reset while the second dictionary-2 entry is being requested.
    lat_mode = 0;
    load_s1();
    build_expect();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(mem_req_valid && mem_req_addr == BASE + 32'd16) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_dict2_read", k < 200, k, 0);
    mon_en = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, done, error, mem_req_valid, d1_en, d2_en, d3_en} == 0,
        {busy, done, error, mem_req_valid, d1_en, d2_en, d3_en}, 0);
    chk("async_reset_addr_vals", {mem_req_addr, d1_val, d2_val, d3_val} == 0,
        {mem_req_addr, d1_val, d2_val, d3_val}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_idle", {busy, done, error, mem_req_valid} == 0,
        {busy, done, error, mem_req_valid}, 0);
    mon_en = 1'b1;
    run_load("after_reset", 1'b0);
    check_s1_literal("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
